// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
// Drives the PC register controls (pc_d/pc_ld/pc_inc), issues one memory read
// per PC over req/ack, holds each fetched word for decode over valid/ready,
// applies branch redirects and latches sticky faults.
// Optional feature macro: FETCH_CTRL_TIMEOUT_EN (REQ wait counter + timeout fault).
module fetch_ctrl #(
   parameter int unsigned WAIT_MAX = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [31:0] pc_q,
   output logic [31:0] pc_d,
   output logic        pc_ld,
   output logic        pc_inc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        ins_valid,
   output logic [31:0] ins_data,
   output logic [31:0] ins_pc,
   input  logic        ins_ready,
   input  logic        redir,
   input  logic [31:0] redir_target,
   output logic        fault,
   output logic [1:0]  fault_code
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_OUT   = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] ins_data_q, ins_data_d;
   logic [31:0] ins_pc_q, ins_pc_d;
   logic [1:0]  fault_code_q, fault_code_d;

   // WAIT_MAX is only meaningful in 1..255; out-of-range values elaborate an
   // empty marker block so the bad setting is visible in the hierarchy.
   if (WAIT_MAX < 1 || WAIT_MAX > 255) begin : g_wait_max_out_of_range
   end

`ifdef FETCH_CTRL_TIMEOUT_EN
   localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);
   logic [7:0] wait_q, wait_d;
   logic       timeout;

   // The last un-acked REQ cycle before the counter would reach WAIT_MAX.
   always_comb begin
      timeout = (wait_q == WAIT_LAST);
   end
`endif

   // Next-state, PC control and handshake outputs; redirect has priority over
   // ack and ready, and FAULT ignores every input except reset.
   always_comb begin
      state_d      = state_q;
      ins_data_d   = ins_data_q;
      ins_pc_d     = ins_pc_q;
      fault_code_d = fault_code_q;
      pc_d         = '0;
      pc_ld        = 1'b0;
      pc_inc       = 1'b0;
      imem_req     = 1'b0;
      imem_addr    = '0;
      ins_valid    = 1'b0;
`ifdef FETCH_CTRL_TIMEOUT_EN
      wait_d       = '0;
`endif

      if (state_q == S_REQ) begin
         imem_req  = 1'b1;
         imem_addr = pc_q;
      end
      if (state_q == S_OUT) begin
         ins_valid = 1'b1;
      end

      if (redir && state_q != S_FAULT) begin
         if (redir_target[1:0] == 2'b00) begin
            pc_ld   = 1'b1;
            pc_d    = redir_target;
            state_d = en ? S_REQ : S_IDLE;
         end else begin
            state_d      = S_FAULT;
            fault_code_d = 2'b01;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (en) begin
                  state_d = S_REQ;
               end
            end
            S_REQ: begin
               if (imem_ack) begin
                  ins_data_d = imem_rdata;
                  ins_pc_d   = pc_q;
                  pc_inc     = 1'b1;
                  pc_d       = pc_q;
                  state_d    = S_OUT;
               end else begin
`ifdef FETCH_CTRL_TIMEOUT_EN
                  if (timeout) begin
                     state_d      = S_FAULT;
                     fault_code_d = 2'b10;
                  end else begin
                     wait_d = wait_q + 8'd1;
                  end
`endif
               end
            end
            S_OUT: begin
               if (ins_ready) begin
                  state_d = en ? S_REQ : S_IDLE;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // State and captured-instruction registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         ins_data_q   <= '0;
         ins_pc_q     <= '0;
         fault_code_q <= '0;
`ifdef FETCH_CTRL_TIMEOUT_EN
         wait_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         ins_data_q   <= ins_data_d;
         ins_pc_q     <= ins_pc_d;
         fault_code_q <= fault_code_d;
`ifdef FETCH_CTRL_TIMEOUT_EN
         wait_q       <= wait_d;
`endif
      end
   end

   assign ins_data   = ins_data_q;
   assign ins_pc     = ins_pc_q;
   assign fault      = (state_q == S_FAULT);
   assign fault_code = fault_code_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vector table, hand sequences and randomized traffic
// for fetch_ctrl, with a PC register and a transaction-level reference model.
module tb_fetch_ctrl;

`ifdef FETCH_CTRL_TIMEOUT_EN
   localparam int unsigned TB_WAIT_MAX = 4;
`else
   localparam int unsigned TB_WAIT_MAX = 255;
`endif
   localparam logic [31:0] PC_RST = 32'h0100_0000;

   logic        clk, rst, en;
   logic [31:0] pc_q, pc_d;
   logic        pc_ld, pc_inc, imem_req, imem_ack, ins_valid, ins_ready, redir, fault;
   logic [31:0] imem_addr, imem_rdata, ins_data, ins_pc, redir_target;
   logic [1:0]  fault_code;

   int n_checks = 0;
   int n_fail   = 0;

   fetch_ctrl #(.WAIT_MAX(TB_WAIT_MAX)) dut (
      .clk(clk), .rst(rst), .en(en), .pc_q(pc_q), .pc_d(pc_d), .pc_ld(pc_ld),
      .pc_inc(pc_inc), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ins_valid(ins_valid),
      .ins_data(ins_data), .ins_pc(ins_pc), .ins_ready(ins_ready),
      .redir(redir), .redir_target(redir_target), .fault(fault),
      .fault_code(fault_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // PC register owned by the environment, controlled by the DUT.
   always @(posedge clk) begin
      if (rst)         pc_q <= PC_RST;
      else if (pc_ld)  pc_q <= pc_d;
      else if (pc_inc) pc_q <= pc_d + 32'd4;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   logic        m_fault, m_busy, m_hold;
   logic [31:0] m_pc, m_word, m_wpc;
   logic [1:0]  m_code;
`ifdef FETCH_CTRL_TIMEOUT_EN
   int unsigned m_waited;
`endif

   task automatic model_reset();
      m_fault = 1'b0; m_busy = 1'b0; m_hold = 1'b0;
      m_pc = PC_RST; m_word = '0; m_wpc = '0; m_code = '0;
`ifdef FETCH_CTRL_TIMEOUT_EN
      m_waited = 0;
`endif
   endtask

   task automatic model_check();
      logic        go, ld, inc;
      logic [31:0] exp_pcd;
      go      = redir && !m_fault;
      ld      = go && (redir_target[1:0] == 2'b00);
      inc     = m_busy && imem_ack && !go;
      exp_pcd = ld ? redir_target : (inc ? m_pc : 32'd0);
      check("m_imem_req",   32'(imem_req),   32'(m_busy));
      check("m_imem_addr",  imem_addr,       m_busy ? m_pc : 32'd0);
      check("m_ins_valid",  32'(ins_valid),  32'(m_hold));
      check("m_ins_data",   ins_data,        m_word);
      check("m_ins_pc",     ins_pc,          m_wpc);
      check("m_pc_ld",      32'(pc_ld),      32'(ld));
      check("m_pc_inc",     32'(pc_inc),     32'(inc));
      check("m_pc_d",       pc_d,            exp_pcd);
      check("m_fault",      32'(fault),      32'(m_fault));
      check("m_fault_code", 32'(fault_code), 32'(m_code));
      check("m_pc_q",       pc_q,            m_pc);
   endtask

   task automatic model_advance();
      if (rst) begin
         model_reset();
      end else if (m_fault) begin
         // sticky
      end else if (redir) begin
         if (redir_target[1:0] == 2'b00) begin
            m_pc = redir_target; m_hold = 1'b0; m_busy = en;
`ifdef FETCH_CTRL_TIMEOUT_EN
            m_waited = 0;
`endif
         end else begin
            m_fault = 1'b1; m_code = 2'b01; m_hold = 1'b0; m_busy = 1'b0;
         end
      end else if (m_busy) begin
         if (imem_ack) begin
            m_word = imem_rdata; m_wpc = m_pc; m_pc = m_pc + 32'd4;
            m_busy = 1'b0; m_hold = 1'b1;
         end else begin
`ifdef FETCH_CTRL_TIMEOUT_EN
            m_waited++;
            if (m_waited == TB_WAIT_MAX) begin
               m_fault = 1'b1; m_code = 2'b10; m_busy = 1'b0;
            end
`endif
         end
      end else if (m_hold) begin
         if (ins_ready) begin
            m_hold = 1'b0; m_busy = en;
`ifdef FETCH_CTRL_TIMEOUT_EN
            m_waited = 0;
`endif
         end
      end else if (en) begin
         m_busy = 1'b1;
`ifdef FETCH_CTRL_TIMEOUT_EN
         m_waited = 0;
`endif
      end
   endtask

   task automatic drive(input logic r, input logic e, input logic a, input logic [31:0] rd,
                        input logic rdy, input logic rr, input logic [31:0] tgt);
      rst = r; en = e; imem_ack = a; imem_rdata = rd;
      ins_ready = rdy; redir = rr; redir_target = tgt;
   endtask

   // One cycle: drive at the falling edge, compare against the model, advance it.
   task automatic step(input logic r, input logic e, input logic a, input logic [31:0] rd,
                       input logic rdy, input logic rr, input logic [31:0] tgt);
      @(negedge clk);
      drive(r, e, a, rd, rdy, rr, tgt);
      #1;
      model_check();
      model_advance();
   endtask

   task automatic hard_reset();
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      @(negedge clk);
      model_reset();
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic en, ack; logic [31:0] rdata; logic ready, redir; logic [31:0] target;
      logic x_req; logic [31:0] x_addr; logic x_valid; logic [31:0] x_data, x_ipc;
      logic x_ld, x_inc; logic [31:0] x_pcd; logic x_fault; logic [1:0] x_code;
      logic [31:0] x_pcq;
   } vec_t;

   vec_t tbl[16];

   initial begin
      drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

      tbl[0] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,
                 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0100_0000};
      tbl[1] = '{1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,
                 1'b1, 32'h0100_0000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0100_0000, 1'b0, 2'b00, 32'h0100_0000};
      for (int i = 2; i <= 7; i++)
         tbl[i] = '{1'b1, 1'b0, 32'h0, (i == 7), 1'b0, 32'h0,
                    1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 32'h0100_0000, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0100_0004};
      tbl[8] = '{1'b1, 1'b1, 32'h1111_1111, 1'b0, 1'b1, 32'h0000_2000,
                 1'b1, 32'h0100_0004, 1'b0, 32'hDEAD_BEEF, 32'h0100_0000, 1'b1, 1'b0, 32'h0000_2000, 1'b0, 2'b00, 32'h0100_0004};
      tbl[9] = '{1'b1, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0,
                 1'b1, 32'h0000_2000, 1'b0, 32'hDEAD_BEEF, 32'h0100_0000, 1'b0, 1'b1, 32'h0000_2000, 1'b0, 2'b00, 32'h0000_2000};
      for (int i = 10; i <= 11; i++)
         tbl[i] = '{1'b0, 1'b0, 32'h0, (i == 11), 1'b0, 32'h0,
                    1'b0, 32'h0, 1'b1, 32'hCAFE_F00D, 32'h0000_2000, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0000_2004};
      for (int i = 12; i <= 13; i++)
         tbl[i] = '{1'b0, 1'b0, 32'h0, 1'b0, (i == 13), 32'h0000_2002,
                    1'b0, 32'h0, 1'b0, 32'hCAFE_F00D, 32'h0000_2000, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0000_2004};
      for (int i = 14; i <= 15; i++)
         tbl[i] = '{1'b1, (i == 15), 32'h0, 1'b0, (i == 14), 32'h0000_3000,
                    1'b0, 32'h0, 1'b0, 32'hCAFE_F00D, 32'h0000_2000, 1'b0, 1'b0, 32'h0, 1'b1, 2'b01, 32'h0000_2004};

      // Reset state.
      hard_reset();
      #1;
      check("rst_imem_req",   32'(imem_req),   32'd0);
      check("rst_imem_addr",  imem_addr,       32'd0);
      check("rst_ins_valid",  32'(ins_valid),  32'd0);
      check("rst_ins_data",   ins_data,        32'd0);
      check("rst_ins_pc",     ins_pc,          32'd0);
      check("rst_pc_ld",      32'(pc_ld),      32'd0);
      check("rst_pc_inc",     32'(pc_inc),     32'd0);
      check("rst_pc_d",       pc_d,            32'd0);
      check("rst_fault",      32'(fault),      32'd0);
      check("rst_fault_code", 32'(fault_code), 32'd0);
      check("rst_pc_q",       pc_q,            PC_RST);

      // Directed table: fetch, decode stall, redirect vs ack, en drop, misaligned fault.
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         drive(1'b0, tbl[i].en, tbl[i].ack, tbl[i].rdata, tbl[i].ready, tbl[i].redir, tbl[i].target);
         #1;
         check($sformatf("v%0d_imem_req", i),   32'(imem_req),   32'(tbl[i].x_req));
         check($sformatf("v%0d_imem_addr", i),  imem_addr,       tbl[i].x_addr);
         check($sformatf("v%0d_ins_valid", i),  32'(ins_valid),  32'(tbl[i].x_valid));
         check($sformatf("v%0d_ins_data", i),   ins_data,        tbl[i].x_data);
         check($sformatf("v%0d_ins_pc", i),     ins_pc,          tbl[i].x_ipc);
         check($sformatf("v%0d_pc_ld", i),      32'(pc_ld),      32'(tbl[i].x_ld));
         check($sformatf("v%0d_pc_inc", i),     32'(pc_inc),     32'(tbl[i].x_inc));
         check($sformatf("v%0d_pc_d", i),       pc_d,            tbl[i].x_pcd);
         check($sformatf("v%0d_fault", i),      32'(fault),      32'(tbl[i].x_fault));
         check($sformatf("v%0d_fault_code", i), 32'(fault_code), 32'(tbl[i].x_code));
         check($sformatf("v%0d_pc_q", i),       pc_q,            tbl[i].x_pcq);
      end

      // en dropped in REQ and OUT: fetch completes, is accepted, then IDLE.
      hard_reset();
      step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      check("endrop_req_held", 32'(imem_req), 32'd1);
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      check("endrop_addr", imem_addr, PC_RST);
      step(1'b0, 1'b0, 1'b1, 32'hA5A5_5A5A, 1'b0, 1'b0, 32'd0);
      check("endrop_inc", 32'(pc_inc), 32'd1);
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      check("endrop_data", ins_data, 32'hA5A5_5A5A);
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
      check("endrop_valid", 32'(ins_valid), 32'd1);
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      check("endrop_idle_req", 32'(imem_req), 32'd0);
      check("endrop_idle_pc", pc_q, PC_RST + 32'd4);

      // PC wrap at the top of the address space is not a fault.
      hard_reset();
      step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      step(1'b0, 1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'd0);
      check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      check("wrap_pc_q", pc_q, 32'd0);
      check("wrap_fault", 32'(fault), 32'd0);
      check("wrap_ins_pc", ins_pc, 32'hFFFF_FFFC);

      // Reset while a request is outstanding abandons it.
      step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
      step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      check("midrst_req_before", 32'(imem_req), 32'd1);
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      check("midrst_req_after", 32'(imem_req), 32'd0);
      check("midrst_pc_q", pc_q, PC_RST);
      check("midrst_ins_data", ins_data, 32'd0);

`ifdef FETCH_CTRL_TIMEOUT_EN
      // No ack: request held WAIT_MAX cycles, then timeout fault.
      hard_reset();
      step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
         check($sformatf("tmo_req_%0d", i), 32'(imem_req), 32'd1);
      end
      step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      check("tmo_req_dropped", 32'(imem_req), 32'd0);
      check("tmo_fault", 32'(fault), 32'd1);
      check("tmo_code", 32'(fault_code), 32'd2);
`endif

      // Randomized traffic against the reference model.
      hard_reset();
      for (int c = 0; c < 4000; c++) begin
         logic        r_rst, r_en, r_ack, r_rdy, r_redir;
         logic [31:0] r_tgt;
         r_rst   = ($urandom % 40) == 0;
         r_en    = ($urandom % 8) != 0;
         r_ack   = m_busy && (($urandom % 3) == 0);
         r_rdy   = ($urandom % 2) == 0;
         r_redir = ($urandom % 12) == 0;
         r_tgt   = $urandom;
         if (($urandom % 6) != 0) r_tgt[1:0] = 2'b00;
         if (($urandom % 10) == 0) r_tgt = 32'hFFFF_FFFC;
         step(r_rst, r_en, r_ack, $urandom, r_rdy, r_redir, r_tgt);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
